// File: rtl/bridge_tx_formatter.sv
// rtl/bridge_tx_formatter.sv - formats bus read responses as "M"+4 hex+CR+LF bytes for the UART
module bridge_tx_formatter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, N3, N2, N1, N0, CR, LF} state_e;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          bvalid_q, bvalid_d;
  logic          busy_q;
  logic          overflow_q;
  logic          push_req, push, pop, xfer;
  logic          unused_bus;

  assign unused_bus = ^{addr_i, wdata_i};

  function automatic logic [7:0] hex(input logic [3:0] n);
    hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign xfer     = bvalid_q & byte_ready_i;
  assign push_req = valid_i & ~rw_i;
  // A full FIFO still takes the beat when the head leaves on the same edge.
  assign push     = push_req & ((count_q != DEPTH_C) | pop);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    byte_d   = byte_q;
    bvalid_d = bvalid_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop      = 1'b1;
        shreg_d  = mem_q[rd_ptr_q];
        byte_d   = 8'h4D;
        bvalid_d = 1'b1;
        state_d  = HDR;
      end
      HDR: if (xfer) begin byte_d = hex(shreg_q[15:12]); state_d = N3; end
      N3:  if (xfer) begin byte_d = hex(shreg_q[11:8]);  state_d = N2; end
      N2:  if (xfer) begin byte_d = hex(shreg_q[7:4]);   state_d = N1; end
      N1:  if (xfer) begin byte_d = hex(shreg_q[3:0]);   state_d = N0; end
      N0:  if (xfer) begin byte_d = 8'h0D;               state_d = CR; end
      CR:  if (xfer) begin byte_d = 8'h0A;               state_d = LF; end
      LF: if (xfer) begin
        // Chain straight into the next frame so there is no idle gap after LF.
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          byte_d  = 8'h4D;
          state_d = HDR;
        end else begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_q     <= 8'h00;
      bvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_q     <= byte_d;
      bvalid_q   <= bvalid_d;
      busy_q     <= (state_d != IDLE) || (count_d != '0);
      overflow_q <= overflow_q | (push_req & ~push);
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = bvalid_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;

endmodule
